ar_burst_seq: RTL
=================

// Module: ar_burst_seq
// PURPOSE
//   Parametrised address register with a burst sequencer. Loads a base address
//   from the program counter or the ALU result, then issues up to BURST_MAX
//   sequential addresses to memory over a req/ack handshake. Sits between the
//   control unit and the memory interface for multi-word fetch and block moves.
// PARAMETERS
//   AW         16  address width in bits
//   BURST_MAX  4   maximum beats per burst; power of two, >= 2
//   STEP       1   address increment per beat; STEP*BURST_MAX <= 2**AW
//   LW = $clog2(BURST_MAX) is a localparam, not overridable
// PORTS
//   clk       in   1    clock, rising edge
//   reset     in   1    asynchronous, active-low reset
//   pc        in   AW   program counter, load source
//   alu_out   in   AW   ALU result, load source
//   rec       in   2    00 hold; 01 q<=pc; 11 q<=alu_out; 10 q<=q+STEP
//   start     in   1    begin a burst from the current or just-loaded q
//   len       in   LW   beats-1; sampled only on an accepted start
//   abort     in   1    synchronous cancel of an active burst
//   mem_req   out  1    address valid toward memory
//   mem_ack   in   1    memory accepted the current address
//   q         out  AW   address register
//   busy      out  1    high in the BURST state
//   done      out  1    one-cycle pulse after the last beat is acknowledged
//   beat      out  LW   index of the beat being presented, 0..len
// BEHAVIOUR
//   Reset: q=0, mem_req=0, busy=0, done=0, beat=0, state=IDLE.
//   The reset is asynchronous and fully effective mid-burst. No done pulse.
//   FSM states: IDLE, BURST.
//   IDLE:
//   - rec acts every cycle; 10 adds STEP modulo 2**AW.
//   - start=1: latch len, set beat=0, go to BURST next edge.
//   - start together with a rec load: q takes the loaded value on the same
//     edge, and the burst begins at that new address.
//   BURST:
//   - mem_req=busy=1, registered from state; first req is 1 cycle after start.
//   - rec and start are ignored.
//   - q and beat are held stable while mem_req=1 and mem_ack=0.
//   - mem_ack with beat<len: q<=next(q), beat<=beat+1.
//   - mem_ack with beat==len: q holds the last address (no increment), go to
//     IDLE, done=1 for exactly 1 cycle.
//   - abort=1: go to IDLE next edge; q and beat keep their current values;
//     no done pulse.
//   - abort and mem_ack in the same cycle: abort wins; that beat counts as
//     not accepted.
//   - len=0 gives a single beat.
//   - Throughput: 1 beat/cycle when mem_ack is held at 1.
//   next(q): linear q+STEP modulo 2**AW (wraps to 0 past the top).
// CONFIGURATION
//   AR_WRAP_BURST_EN defined: next(q) wraps within an aligned window of
//     BURST_MAX*STEP bytes. Bits above the window are held; the low field
//     increments modulo the window. This is a critical-word-first line fill.
//     rec=10 in IDLE stays linear.
//   AR_WRAP_BURST_EN undefined: next(q) is linear as above. No window logic
//     is built.
// TESTING
//   1. reset low mid-burst, q=0x1234 -> q=0, mem_req=0, busy=0, done=0,
//      beat=0 immediately.
//   2. rec=01 pc=0x00F0, then start len=3, mem_ack tied 1 -> q=F0,F1,F2,F3
//      on 4 consecutive cycles; done pulses once; q stays 0x00F3.
//   3. rec=11 alu_out=0xFFFE with start len=3, linear build ->
//      q=FFFE,FFFF,0000,0001.
//   4. Burst with mem_ack low for 3 cycles on beat 1 -> q and beat held
//      throughout; rec=01 during the burst has no effect.
//   5. abort on beat 2 with mem_ack=1 in the same cycle -> IDLE, q unchanged,
//      done stays 0.
//   6. AR_WRAP_BURST_EN, BURST_MAX=4, q=0x0106, len=3 ->
//      q=0106,0107,0104,0105.

Source files
------------

// File: rtl/ar_burst_seq.sv
// ---------------------------------------------------------------------------
// ar_burst_seq
//   Address register with a burst sequencer. It loads a base address from
//   the program counter or the ALU result and then presents up to BURST_MAX
//   sequential addresses to memory, one per accepted req/ack handshake.
//
//   Build option: define AR_WRAP_BURST_EN to make the in-burst increment
//   wrap inside an aligned window of BURST_MAX*STEP (critical-word-first
//   line fill). The window must be a power of two. When the macro is
//   undefined the increment is plain linear and no window logic exists.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   pc       in   [AW-1:0] load source (rec=01)
//   alu_out  in   [AW-1:0] load source (rec=11)
//   rec      in   [1:0]    00 hold, 01 load pc, 11 load alu_out, 10 q+STEP
//   start    in   begin a burst (IDLE only)
//   len      in   [LW-1:0] beats-1, captured on an accepted start
//   abort    in   cancel an active burst, no done pulse
//   mem_req  out  address valid toward memory
//   mem_ack  in   memory accepted the current address
//   q        out  [AW-1:0] address register
//   busy     out  high while bursting
//   done     out  one-cycle pulse after the last beat is acknowledged
//   beat     out  [LW-1:0] index of the beat being presented
// ---------------------------------------------------------------------------
module ar_burst_seq #(
   parameter int AW        = 16,
   parameter int BURST_MAX = 4,
   parameter int STEP      = 1,
   localparam int LW       = $clog2(BURST_MAX)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc,
   input  logic [AW-1:0] alu_out,
   input  logic [1:0]    rec,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic          abort,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic [AW-1:0] q,
   output logic          busy,
   output logic          done,
   output logic [LW-1:0] beat
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam logic [AW-1:0] STEP_V = AW'(STEP);

   state_t        state, state_nxt;
   logic [LW-1:0] len_r;
   logic          last_beat;
   logic          accept;
   logic [AW-1:0] q_lin;
   logic [AW-1:0] q_next;

   assign last_beat = (beat == len_r);
   // abort beats a simultaneous ack: that beat is treated as not accepted
   assign accept    = (state == BURST) && mem_ack && !abort;
   assign q_lin     = q + STEP_V;

`ifdef AR_WRAP_BURST_EN
   localparam int            WB       = $clog2(BURST_MAX * STEP);
   localparam logic [AW-1:0] WIN_MASK = {AW{1'b1}} >> (AW - WB);
   // upper bits stay put; only the in-window field rolls over
   assign q_next = (q & ~WIN_MASK) | (q_lin & WIN_MASK);
`else
   assign q_next = q_lin;
`endif

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = BURST;
         BURST: begin
            if (abort)                    state_nxt = IDLE;
            else if (mem_ack && last_beat) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decoded straight from the state register
   always_comb begin
      mem_req = 1'b0;
      busy    = 1'b0;
      if (state == BURST) begin
         mem_req = 1'b1;
         busy    = 1'b1;
      end
   end

   // address, beat counter, captured length and done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q     <= '0;
         beat  <= '0;
         len_r <= '0;
         done  <= 1'b0;
      end else begin
         done <= accept && last_beat;
         if (state == IDLE) begin
            // a load on the start edge becomes the first burst address
            case (rec)
               2'b01:   q <= pc;
               2'b11:   q <= alu_out;
               2'b10:   q <= q_lin;
               default: ;
            endcase
            if (start) begin
               len_r <= len;
               beat  <= '0;
            end
         end else if (accept && !last_beat) begin
            // the last beat leaves q on the final address
            q    <= q_next;
            beat <= beat + 1'b1;
         end
      end
   end

endmodule
